// File: rtl/pwm_compare_pkg.sv
// Shared widths, FSM state encoding and compare helper for the PWM compare block.
// The comparator and the shadow register pair both import this package.
package pwm_compare_pkg;

    localparam int CNT_W = 16;
    localparam int PER_W = 8;

    localparam logic [PER_W-1:0] PERIODS_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_WRAP = 2'd1,
        ST_ACTIVE    = 2'd2,
        ST_STOPPING  = 2'd3
    } state_t;

    // Active level while the count is below the threshold, inverted by polarity.
    function automatic logic pwm_level(input logic [CNT_W-1:0] cnt,
                                       input logic [CNT_W-1:0] duty,
                                       input logic             pol);
        return pol ^ (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_shadow_reg.sv
// Pending/active configuration pair. A new setting is parked in the pending
// register and only reaches the comparator when the controller says apply.
module pwm_shadow_reg
    import pwm_compare_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_duty,
    input  logic             cfg_pol,
    input  logic             apply,
    output logic             cfg_ready,
    output logic [CNT_W-1:0] active_duty,
    output logic             active_pol
);

    logic             pending;
    logic [CNT_W-1:0] pending_duty;
    logic             pending_pol;
    logic             xfer;

    assign cfg_ready = !pending;
    assign xfer      = cfg_valid && !pending;

    // xfer and the pending->active copy are mutually exclusive, so a transfer
    // landing on an apply cycle simply waits for the next apply.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending      <= 1'b0;
            pending_duty <= '0;
            pending_pol  <= 1'b0;
            active_duty  <= '0;
            active_pol   <= 1'b0;
        end else begin
            if (xfer) begin
                pending      <= 1'b1;
                pending_duty <= cfg_duty;
                pending_pol  <= cfg_pol;
            end
            if (pending && apply) begin
                active_duty <= pending_duty;
                active_pol  <= pending_pol;
                pending     <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pwm_compare.sv
// PWM comparator slaved to an external free-running 16-bit counter. Starts and
// stops only on counter wrap so every emitted period is complete.
module pwm_compare
    import pwm_compare_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             cnt_en,
    input  logic [CNT_W-1:0] cnt_q,
    input  logic             cnt_tc,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_duty,
    input  logic             cfg_pol,
    output logic             cfg_ready,
    output logic             pwm,
    output logic             match,
    output logic             period_done,
    output logic [PER_W-1:0] periods,
    output logic             busy
);

    state_t           state;
    state_t           state_next;
    logic             boundary;
    logic             in_run;
    logic             apply;
    logic             start_run;
    logic [CNT_W-1:0] active_duty;
    logic             active_pol;

    assign boundary  = cnt_en && cnt_tc;
    assign in_run    = (state == ST_ACTIVE) || (state == ST_STOPPING);
    assign apply     = (state == ST_IDLE) || boundary;
    assign start_run = (state == ST_IDLE) && run;
    assign busy      = (state != ST_IDLE);

    pwm_shadow_reg u_shadow (
        .clk         (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_duty    (cfg_duty),
        .cfg_pol     (cfg_pol),
        .apply       (apply),
        .cfg_ready   (cfg_ready),
        .active_duty (active_duty),
        .active_pol  (active_pol)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Dropping run in WAIT_WRAP wins over a coincident wrap; in STOPPING the
    // wrap wins, since that period has already been emitted in full.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (run) state_next = ST_WAIT_WRAP;
            end
            ST_WAIT_WRAP: begin
                if (!run)          state_next = ST_IDLE;
                else if (boundary) state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (!run) state_next = ST_STOPPING;
            end
            ST_STOPPING: begin
                if (boundary) state_next = ST_IDLE;
                else if (run) state_next = ST_ACTIVE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm         <= 1'b0;
            match       <= 1'b0;
            period_done <= 1'b0;
            periods     <= '0;
        end else begin
            if (in_run) begin
                pwm <= pwm_level(cnt_q, active_duty, active_pol);
            end else begin
                pwm <= active_pol;
            end

            match       <= in_run && cnt_en && (cnt_q == active_duty) && (active_duty != '0);
            period_done <= in_run && boundary;

            if (start_run) begin
                periods <= '0;
            end else if (in_run && boundary && (periods != PERIODS_MAX)) begin
                periods <= periods + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_compare.sv
// Directed self-checking bench for pwm_compare; the bench plays the upstream
// counter and may preload it to jump straight to interesting counts.
module tb_pwm_compare;

    logic        clk = 1'b0;
    logic        reset;
    logic        cnt_en;
    logic [15:0] cnt_q;
    logic        cnt_tc;
    logic        run;
    logic        cfg_valid;
    logic [15:0] cfg_duty;
    logic        cfg_pol;
    logic        cfg_ready;
    logic        pwm;
    logic        match;
    logic        period_done;
    logic [7:0]  periods;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] duty;
        logic        pol;
        logic [15:0] cnt;
        logic        en;
        logic        exp_pwm;
        logic        exp_match;
    } vec_t;

    vec_t vecs[16];

    pwm_compare dut (
        .clk         (clk),
        .reset       (reset),
        .cnt_en      (cnt_en),
        .cnt_q       (cnt_q),
        .cnt_tc      (cnt_tc),
        .run         (run),
        .cfg_valid   (cfg_valid),
        .cfg_duty    (cfg_duty),
        .cfg_pol     (cfg_pol),
        .cfg_ready   (cfg_ready),
        .pwm         (pwm),
        .match       (match),
        .period_done (period_done),
        .periods     (periods),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock; the emulated upstream counter advances with cnt_en.
    task automatic tick();
        @(posedge clk);
        #1;
        if (cnt_en) cnt_q = cnt_q + 16'd1;
        cnt_tc = (cnt_q == 16'hFFFF);
    endtask

    task automatic set_cnt(input logic [15:0] v);
        cnt_q  = v;
        cnt_tc = (v == 16'hFFFF);
    endtask

    task automatic configure(input logic [15:0] d, input logic p);
        int k = 0;
        while (!cfg_ready && k < 200) begin
            tick();
            k++;
        end
        if (!cfg_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL cfg_ready_timeout: got 0 expected 1");
        end
        cfg_duty  = d;
        cfg_pol   = p;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    // From IDLE: load config, request run, then wrap into ACTIVE at count 0.
    task automatic start(input logic [15:0] d, input logic p);
        configure(d, p);
        run = 1'b1;
        tick();
        set_cnt(16'hFFFF);
        tick();
    endtask

    initial begin
        int pulses;

        vecs[0]  = '{16'h4000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{16'h4000, 1'b0, 16'h3FFF, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{16'h4000, 1'b0, 16'h4000, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{16'h4000, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{16'h4000, 1'b0, 16'h4000, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{16'h4000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{16'h4000, 1'b1, 16'h4000, 1'b1, 1'b1, 1'b1};
        vecs[7]  = '{16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{16'h0000, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{16'hFFFF, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1};
        vecs[11] = '{16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{16'h8000, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{16'h8000, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{16'h0001, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b1};

        reset     = 1'b1;
        cnt_en    = 1'b1;
        cnt_q     = 16'h0000;
        cnt_tc    = 1'b0;
        run       = 1'b0;
        cfg_valid = 1'b0;
        cfg_duty  = 16'h0000;
        cfg_pol   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_pwm", pwm, 0);
        check("rst_match", match, 0);
        check("rst_period_done", period_done, 0);
        check("rst_periods", periods, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_busy", busy, 0);

        // Run dropped while waiting for the first wrap returns to IDLE.
        configure(16'h4000, 1'b0);
        run = 1'b1;
        tick();
        check("wait_busy", busy, 1);
        run = 1'b0;
        tick();
        check("wait_abort_busy", busy, 0);

        // Duty 4000 pol 0: high below threshold, one match, one period_done.
        start(16'h4000, 1'b0);
        check("start_busy", busy, 1);
        check("start_no_pd", period_done, 0);
        tick();
        check("p1_pwm_cnt0", pwm, 1);
        set_cnt(16'h3FFE);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (match) pulses++;
            if (i == 1) check("p1_pwm_3fff", pwm, 1);
            if (i == 2) check("p1_pwm_4000", pwm, 0);
        end
        check("p1_match_count", pulses, 1);
        set_cnt(16'hFFFE);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (period_done) pulses++;
        end
        check("p1_pd_count", pulses, 1);
        check("p1_periods", periods, 1);

        // Mid-period transfer waits in pending until the wrap.
        set_cnt(16'h1000);
        configure(16'h8000, 1'b0);
        check("mid_ready_low", cfg_ready, 0);
        set_cnt(16'h5000);
        tick();
        check("mid_old_duty_pwm", pwm, 0);
        check("mid_ready_still_low", cfg_ready, 0);
        set_cnt(16'hFFFF);
        tick();
        check("mid_ready_after_wrap", cfg_ready, 1);
        set_cnt(16'h5000);
        tick();
        check("mid_new_duty_pwm", pwm, 1);

        // Table: load each config through a wrap, then probe one count.
        for (int i = 0; i < 16; i++) begin
            configure(vecs[i].duty, vecs[i].pol);
            set_cnt(16'hFFFF);
            tick();
            set_cnt(vecs[i].cnt);
            cnt_en = vecs[i].en;
            tick();
            check($sformatf("vec%0d_pwm", i), pwm, vecs[i].exp_pwm);
            check($sformatf("vec%0d_match", i), match, vecs[i].exp_match);
            cnt_en = 1'b1;
        end

        // Transfer on a wrap cycle: the new value waits a full period.
        set_cnt(16'hFFFF);
        cfg_duty  = 16'hC000;
        cfg_pol   = 1'b0;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        check("wrapx_ready_low", cfg_ready, 0);
        set_cnt(16'h8000);
        tick();
        check("wrapx_old_pwm", pwm, 0);
        set_cnt(16'hFFFF);
        tick();
        set_cnt(16'h8000);
        tick();
        check("wrapx_new_pwm", pwm, 1);
        check("wrapx_ready_high", cfg_ready, 1);

        // Stop request at count 1000 finishes the period, then IDLE.
        set_cnt(16'h1000);
        run = 1'b0;
        tick();
        check("stop_busy", busy, 1);
        set_cnt(16'hFFFE);
        pulses = 0;
        tick();
        if (period_done) pulses++;
        tick();
        if (period_done) pulses++;
        check("stop_pd_at_wrap", period_done, 1);
        check("stop_idle", busy, 0);
        tick();
        if (period_done) pulses++;
        check("stop_pd_count", pulses, 1);
        check("stop_pwm_inactive", pwm, 0);

        // Saturation: every cycle preloaded to FFFF is a wrap.
        start(16'h4000, 1'b0);
        for (int i = 0; i < 300; i++) begin
            set_cnt(16'hFFFF);
            tick();
            if (i == 9) check("sat_periods_10", periods, 10);
        end
        check("sat_periods_ff", periods, 8'hFF);
        run = 1'b0;
        set_cnt(16'hFFFF);
        tick();
        set_cnt(16'hFFFF);
        tick();
        check("sat_idle", busy, 0);
        check("sat_hold_ff", periods, 8'hFF);
        run = 1'b1;
        tick();
        check("sat_clear", periods, 0);

        // Reset mid-period in ACTIVE with pol 1 and a coincident transfer.
        configure(16'h4000, 1'b1);
        set_cnt(16'hFFFF);
        tick();
        set_cnt(16'h5000);
        tick();
        check("prerst_pwm", pwm, 1);
        set_cnt(16'h2000);
        reset     = 1'b1;
        cfg_valid = 1'b1;
        cfg_duty  = 16'h1234;
        tick();
        check("mrst_pwm", pwm, 0);
        check("mrst_match", match, 0);
        check("mrst_period_done", period_done, 0);
        check("mrst_periods", periods, 0);
        check("mrst_cfg_ready", cfg_ready, 1);
        check("mrst_busy", busy, 0);
        reset     = 1'b0;
        cfg_valid = 1'b0;
        run       = 1'b0;
        tick();
        check("post_rst_ready", cfg_ready, 1);
        check("post_rst_pwm", pwm, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
